rv_inst_encoder: RTL and testbench
==================================

// Module: rv_inst_encoder
// PURPOSE
//   Streaming RV32I instruction encoder: packs symbolic fields (op, rd, rs1, rs2, imm)
//   into 32-bit instruction words and writes them sequentially into instruction memory.
//   Producer side of the decode stage: generates the exact subset the core decodes
//   (add/sub/xor/srl/or/and/addi/lw/sw/beq/blt/jalr). Used for boot/self-test program load.
// PARAMETERS
//   ADDR_W     10   instruction-memory word-address width
//   BASE_ADDR  0    first word address written after start
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset, synchronous, active-high
//   start      in   1       pulse: arm encoder, addr<=BASE_ADDR, count<=0
//   in_valid   in   1       field beat valid
//   in_ready   out  1       encoder accepts beat (state==RUN)
//   in_op      in   4       op select (enum in package)
//   in_rd      in   5       destination register
//   in_rs1     in   5       source register 1
//   in_rs2     in   5       source register 2
//   in_imm     in   32      signed immediate (byte offset for branches)
//   in_last    in   1       final beat of program
//   mem_we     out  1       write strobe, one cycle per word
//   mem_addr   out  ADDR_W  word address
//   mem_wdata  out  32      encoded instruction
//   count      out  ADDR_W+1 words written since start
//   done       out  1       level: last word written
//   err        out  1       level, sticky until start/rst
//   err_code   out  2       1=illegal op, 2=imm out of range, 3=address overflow
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready, mem_we, done, err=0; mem_addr=BASE_ADDR; mem_wdata, count, err_code=0.
//   - FSM IDLE -start-> RUN; RUN -accepted in_last-> DONE; RUN -error-> ERR; DONE/ERR -start-> RUN.
//     start ignored in RUN. in_valid ignored outside RUN (in_ready=0).
//   - Accept = in_valid & in_ready. Throughput 1 word/cycle; latency 1: beat accepted in cycle N
//     -> mem_we=1 with mem_addr/mem_wdata valid in N+1. mem_addr increments after each write.
//   - Op enum: 0 ADD,1 SUB,2 XOR,3 SRL,4 OR,5 AND (opcode 0110011, funct7 0100000 for SUB only,
//     funct3 000/000/100/101/110/111); 6 ADDI 0010011 f3 000; 7 LW 0000011 f3 010;
//     8 SW 0100011 f3 010; 9 BEQ 1100011 f3 000; 10 BLT 1100011 f3 100; 11 JALR 1100111 f3 000.
//   - Fields: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7];
//     B imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]. Unused fields zero
//     (rs2 zero for I-type; rd zero for S/B).
//   - Ops 12-15: no write, err=1, err_code=1, -> ERR. Error beat consumes no address.
//   - Overflow: beat accepted when count==2^ADDR_W -> no write, err_code=3, -> ERR.
//     Last in-range address is written normally; mem_addr wraps only via start.
//   - done stays 1 in DONE until start; count holds its value in DONE/ERR.
//   - rst mid-operation: pending registered write dropped (mem_we=0 next cycle), all regs reset.
//   - Simultaneous start & rst: rst wins.
// CONFIGURATION
//   IMM_RANGE_CHK_EN defined: I/S imm outside -2048..2047, or B imm outside -4096..4094 or odd
//     -> no write, err_code=2, -> ERR.
//   Not defined: no check; imm silently truncated to field bits (B drops imm[0]).
// STRUCTURE
//   rv_enc_pkg: op enum, OPC_* opcodes, F3_*/F7_* constants, err_code enum, FSM state type.
//   Sub-module rv_inst_pack: combinational field packer + illegal/range flags;
//   top holds FSM, address/count counters, output register stage.
// TESTING
//   start; ADDI rd=1 rs1=0 imm=5 -> next cycle mem_we=1, addr=0, wdata=0x00500093.
//   SUB rd=3 rs1=1 rs2=2 then SW rs1=1 rs2=2 imm=8 back-to-back -> 0x402081B3 @0, 0x0020A423 @1.
//   BEQ rs1=1 rs2=2 imm=-4, JALR rd=1 rs1=5 imm=0 in_last -> 0xFE208EE3, 0x000280E7; done=1, count=2.
//   ADDI imm=2048: with IMM_RANGE_CHK_EN -> no mem_we, err=1, code=2; without -> 0x80000093.
//   op=13 -> err_code=1, no write; start re-arms -> addr=BASE_ADDR, err=0.
//   ADDR_W=2: 5 beats, none last -> 4 writes @0..3, 5th err_code=3; rst mid-stream drops pending write.

Source files
------------

// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_enc_pkg
// Description : Shared types and RV32I encoding constants for the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_SRL  = 4'd3,
        OP_OR   = 4'd4,
        OP_AND  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BLT  = 4'd10,
        OP_JALR = 4'd11
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ILLEGAL_OP = 2'd1,
        ERR_IMM_RANGE  = 2'd2,
        ERR_ADDR_OVF   = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // True when imm is representable as a signed 12-bit value (-2048..2047).
    function automatic logic imm_fits_12(input logic [31:0] imm);
        return (imm[31:11] == {21{imm[11]}});
    endfunction

    // Branch offsets: signed 13-bit and halfword aligned (-4096..4094, even).
    function automatic logic imm_fits_b(input logic [31:0] imm);
        return (imm[31:12] == {20{imm[12]}}) && !imm[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_inst_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_inst_encoder_if
// Description : Field-beat input and instruction-memory write bus of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output start, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code
    );

    modport slave (
        input  start, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, count, done, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/rv_inst_pack.sv
`default_nettype none
// ============================================================================
// Module      : rv_inst_pack
// Description : Combinational RV32I field packer with illegal-op and immediate
//               range flags. Range checking enabled by IMM_RANGE_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_inst_pack
    import rv_enc_pkg::*;
(
    input  wire logic [3:0]  i_op,
    input  wire logic [4:0]  i_rd,
    input  wire logic [4:0]  i_rs1,
    input  wire logic [4:0]  i_rs2,
    input  wire logic [31:0] i_imm,
    output logic      [31:0] o_word,
    output logic             o_illegal,
    output logic             o_imm_bad
);

    logic w_i_fmt;
    logic w_s_fmt;
    logic w_b_fmt;

    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        w_i_fmt   = 1'b0;
        w_s_fmt   = 1'b0;
        w_b_fmt   = 1'b0;
        case (op_e'(i_op))
            OP_ADD:  o_word = {F7_BASE, i_rs2, i_rs1, F3_ADD_SUB, i_rd, OPC_OP};
            OP_SUB:  o_word = {F7_SUB,  i_rs2, i_rs1, F3_ADD_SUB, i_rd, OPC_OP};
            OP_XOR:  o_word = {F7_BASE, i_rs2, i_rs1, F3_XOR,     i_rd, OPC_OP};
            OP_SRL:  o_word = {F7_BASE, i_rs2, i_rs1, F3_SRL,     i_rd, OPC_OP};
            OP_OR:   o_word = {F7_BASE, i_rs2, i_rs1, F3_OR,      i_rd, OPC_OP};
            OP_AND:  o_word = {F7_BASE, i_rs2, i_rs1, F3_AND,     i_rd, OPC_OP};
            OP_ADDI: begin
                w_i_fmt = 1'b1;
                o_word  = {i_imm[11:0], i_rs1, F3_ADDI, i_rd, OPC_OP_IMM};
            end
            OP_LW: begin
                w_i_fmt = 1'b1;
                o_word  = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
            end
            OP_JALR: begin
                w_i_fmt = 1'b1;
                o_word  = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OPC_JALR};
            end
            OP_SW: begin
                w_s_fmt = 1'b1;
                o_word  = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OPC_STORE};
            end
            OP_BEQ: begin
                w_b_fmt = 1'b1;
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                           i_imm[4:1], i_imm[11], OPC_BRANCH};
            end
            OP_BLT: begin
                w_b_fmt = 1'b1;
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BLT,
                           i_imm[4:1], i_imm[11], OPC_BRANCH};
            end
            default: o_illegal = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHK_EN
    assign o_imm_bad = ((w_i_fmt | w_s_fmt) & ~imm_fits_12(i_imm))
                     | (w_b_fmt & ~imm_fits_b(i_imm));
`else
    // Without checking, upper immediate bits and format flags are simply dropped.
    logic w_unused;
    assign w_unused  = ^{i_imm[31:13], w_i_fmt, w_s_fmt, w_b_fmt};
    assign o_imm_bad = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/rv_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_inst_encoder
// Description : Streaming RV32I encoder writing packed words to instruction
//               memory. Optional immediate range check: IMM_RANGE_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_inst_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rv_inst_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_cap     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] c_one_a   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_one_c   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W:0]   r_count;
    err_code_e         r_err_code;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_imm_bad;
    logic              w_accept;
    logic              w_ovf;
    logic              w_fault;
    logic              w_write;
    logic              w_arm;
    err_code_e         w_err_sel;

    rv_inst_pack u_pack (
        .i_op      (bus.in_op),
        .i_rd      (bus.in_rd),
        .i_rs1     (bus.in_rs1),
        .i_rs2     (bus.in_rs2),
        .i_imm     (bus.in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal),
        .o_imm_bad (w_imm_bad)
    );

    assign w_accept = bus.in_valid & (r_state == ST_RUN);
    assign w_ovf    = (r_count == c_cap);
    assign w_fault  = w_illegal | w_imm_bad | w_ovf;
    assign w_write  = w_accept & ~w_fault;
    assign w_arm    = bus.start & (r_state != ST_RUN);

    // Faults are prioritised: illegal op, then immediate range, then overflow.
    always_comb begin
        w_err_sel = ERR_ADDR_OVF;
        if (w_illegal) begin
            w_err_sel = ERR_ILLEGAL_OP;
        end else if (w_imm_bad) begin
            w_err_sel = ERR_IMM_RANGE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_nxt = ST_ERR;
                    end else if (bus.in_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // mem_addr shows the address of the most recent write; r_next_addr leads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= c_base;
            r_next_addr <= c_base;
            r_mem_wdata <= 32'd0;
            r_count     <= '0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_mem_we <= w_write;
            if (w_arm) begin
                r_mem_addr  <= c_base;
                r_next_addr <= c_base;
                r_count     <= '0;
                r_err_code  <= ERR_NONE;
            end else if (w_write) begin
                r_mem_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + c_one_a;
                r_mem_wdata <= w_word;
                r_count     <= r_count + c_one_c;
            end else if (w_accept) begin
                r_err_code  <= w_err_sel;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_RUN);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.count     = r_count;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.err       = (r_state == ST_ERR);
    assign bus.err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rv_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_inst_encoder
// Description : Self-checking bench: directed programs plus random beats
//               against a behavioural encoder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_inst_encoder;

    localparam int AW   = 2;
    localparam int BASE = 0;
    localparam int CAP  = 1 << AW;

`ifdef IMM_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_inst_encoder_if #(.ADDR_W(AW)) bus ();

    rv_inst_encoder #(
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0 idle, 1 run, 2 done, 3 error.
    int          m_mode;
    bit          m_we;
    int          m_addr;
    int          m_next;
    logic [31:0] m_wdata;
    int          m_count;
    int          m_code;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] encode(input int op, input logic [31:0] rd,
                                           input logic [31:0] rs1, input logic [31:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] f3;
        logic [31:0] opc;
        logic [31:0] w;
        int          r_f3 [6] = '{0, 0, 4, 5, 6, 7};
        w = 0;
        if (op <= 5) begin
            f3 = r_f3[op];
            w  = ((op == 1) ? (32'd32 << 25) : 32'd0) + (rs2 << 20) + (rs1 << 15)
               + (f3 << 12) + (rd << 7) + 32'd51;
        end else if (op == 6 || op == 7 || op == 11) begin
            opc = (op == 6) ? 32'd19 : (op == 7) ? 32'd3 : 32'd103;
            f3  = (op == 7) ? 32'd2 : 32'd0;
            w   = ((imm & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + opc;
        end else if (op == 8) begin
            w = (((imm >> 5) & 32'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (32'd2 << 12)
              + ((imm & 32'h1F) << 7) + 32'd35;
        end else if (op == 9 || op == 10) begin
            f3 = (op == 10) ? 32'd4 : 32'd0;
            w  = (((imm >> 12) & 32'd1) << 31) + (((imm >> 5) & 32'd63) << 25)
               + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
               + (((imm >> 1) & 32'd15) << 8) + (((imm >> 11) & 32'd1) << 7) + 32'd99;
        end
        return w;
    endfunction

    function automatic bit imm_out_of_range(input int op, input logic [31:0] imm);
        int si;
        si = imm;
        if (op == 6 || op == 7 || op == 8 || op == 11)
            return (si < -2048) || (si > 2047);
        if (op == 9 || op == 10)
            return (si < -4096) || (si > 4094) || (si % 2 != 0);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_we    = 1'b0;
        m_addr  = BASE;
        m_next  = BASE;
        m_wdata = 32'd0;
        m_count = 0;
        m_code  = 0;
    endtask

    // Advance the model with the inputs held across this edge, then compare.
    task automatic step();
        int op;
        op = int'(bus.in_op);
        if (rst) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (m_mode != 1) begin
                if (bus.start) begin
                    m_mode  = 1;
                    m_addr  = BASE;
                    m_next  = BASE;
                    m_count = 0;
                    m_code  = 0;
                end
            end else if (bus.in_valid) begin
                if (op >= 12) begin
                    m_mode = 3; m_code = 1;
                end else if (RANGE_CHK && imm_out_of_range(op, bus.in_imm)) begin
                    m_mode = 3; m_code = 2;
                end else if (m_count == CAP) begin
                    m_mode = 3; m_code = 3;
                end else begin
                    m_we    = 1'b1;
                    m_addr  = m_next;
                    m_next  = (m_next + 1) % CAP;
                    m_wdata = encode(op, 32'(bus.in_rd), 32'(bus.in_rs1),
                                     32'(bus.in_rs2), bus.in_imm);
                    m_count = m_count + 1;
                    if (bus.in_last) m_mode = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("in_ready",  32'(bus.in_ready),  32'(m_mode == 1));
        check_eq("mem_we",    32'(bus.mem_we),    32'(m_we));
        check_eq("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
        check_eq("mem_wdata", bus.mem_wdata,      m_wdata);
        check_eq("count",     32'(bus.count),     32'(m_count));
        check_eq("done",      32'(bus.done),      32'(m_mode == 2));
        check_eq("err",       32'(bus.err),       32'(m_mode == 3));
        check_eq("err_code",  32'(bus.err_code),  32'(m_code));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic beat(input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit last);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'(op);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = imm;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    logic [31:0] imm_pool [12] = '{32'd0, 32'd5, 32'd2047, 32'd2048, 32'hFFFFF800,
                                   32'hFFFFF7FF, 32'd4094, 32'd4095, 32'hFFFFF000,
                                   32'hFFFFEFFE, 32'hFFFFFFFC, 32'd12};

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = 4'd0;
        bus.in_rd    = 5'd0;
        bus.in_rs1   = 5'd0;
        bus.in_rs2   = 5'd0;
        bus.in_imm   = 32'd0;
        bus.in_last  = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();

        // Single ADDI program.
        pulse_start();
        beat(6, 1, 0, 0, 32'd5, 1'b1);
        check_eq("addi_word", bus.mem_wdata, 32'h00500093);
        step();

        // SUB then SW back-to-back.
        pulse_start();
        beat(1, 3, 1, 2, 32'd0, 1'b0);
        check_eq("sub_word", bus.mem_wdata, 32'h402081B3);
        beat(8, 0, 1, 2, 32'd8, 1'b1);
        check_eq("sw_word", bus.mem_wdata, 32'h0020A423);
        check_eq("sw_addr", 32'(bus.mem_addr), 32'd1);

        // BEQ with negative offset then JALR as last beat.
        pulse_start();
        beat(9, 0, 1, 2, 32'hFFFFFFFC, 1'b0);
        check_eq("beq_word", bus.mem_wdata, 32'hFE208EE3);
        beat(11, 1, 5, 0, 32'd0, 1'b1);
        check_eq("jalr_word", bus.mem_wdata, 32'h000280E7);
        check_eq("jalr_done", 32'(bus.done), 32'd1);
        check_eq("jalr_count", 32'(bus.count), 32'd2);
        step();

        // Immediate just past the I-type range.
        pulse_start();
        beat(6, 1, 0, 0, 32'd2048, 1'b1);
        check_eq("addi_2048", RANGE_CHK ? 32'(bus.err_code) : bus.mem_wdata,
                 RANGE_CHK ? 32'd2 : 32'h80000093);
        step();

        // Illegal op, then re-arm.
        pulse_start();
        beat(13, 1, 2, 3, 32'd0, 1'b0);
        step();
        pulse_start();
        check_eq("rearm_err", 32'(bus.err), 32'd0);

        // Address overflow: CAP writes, then the next beat errors.
        for (int i = 0; i <= CAP; i++) beat(6, i + 1, 0, 0, 32'(i), 1'b0);
        check_eq("ovf_code", 32'(bus.err_code), 32'd3);
        step();

        // Reset coincident with an accepted beat drops the write.
        pulse_start();
        rst = 1'b1;
        beat(0, 1, 2, 3, 32'd0, 1'b0);
        rst = 1'b0;
        check_eq("rst_drop_we", 32'(bus.mem_we), 32'd0);

        // start together with reset: reset wins.
        rst = 1'b1;
        pulse_start();
        rst = 1'b0;
        check_eq("rst_start_rdy", 32'(bus.in_ready), 32'd0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 79) == 0);
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_op    = ($urandom_range(0, 9) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                      : 4'($urandom_range(0, 11));
            bus.in_rd    = 5'($urandom);
            bus.in_rs1   = 5'($urandom);
            bus.in_rs2   = 5'($urandom);
            bus.in_imm   = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                      : imm_pool[$urandom_range(0, 11)];
            bus.in_last  = ($urandom_range(0, 4) == 0);
            step();
        end
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
